// File: rtl/l1_ld_mem_sched.sv
// ============================================================================
// Module   : l1_ld_mem_sched
// Purpose  : Scheduler in front of the L1 load-cache data/tag array. The array
//            has one synchronous read port and one write port. The scheduler
//            shares the write port between refill and update requesters with
//            round-robin arbitration. It runs full-array zeroing sweeps
//            (flush) and keeps a read coherent with a write to the same
//            address in the same cycle. All traffic is held off until the
//            array reports that its post-reset clear has finished.
// Revision : 1.0 - initial release
//
// Build option:
//   L1_LD_MEM_SCHED_BYPASS_EN - when defined, a read that collides with a
//   same-cycle write is accepted, and the write data is forwarded as the read
//   response. When undefined, the colliding read is stalled for one cycle.
//
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   i_mem_ready              array post-reset clear complete
//   i_rd_val/i_rd_addr       read request        -> o_rd_ack
//   o_rd_data_val/o_rd_data  read response, 1 cycle after o_rd_ack
//   i_refill_*               refill write request -> o_refill_ack
//   i_upd_*                  update write request -> o_upd_ack
//   i_flush_req              request a zeroing sweep (level, sampled)
//   o_flush_done             1-cycle pulse in the first cycle after a sweep
//   o_busy                   high in INIT or FLUSH
//   o_mem_ren/o_mem_raddr    array read port; i_mem_rdata returns 1 cycle later
//   o_mem_wen/o_mem_waddr/o_mem_wdata  array write port
// ============================================================================
`default_nettype none

module l1_ld_mem_sched #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_mem_ready,
  input  logic             i_rd_val,
  input  logic [c_AW-1:0]  i_rd_addr,
  output logic             o_rd_ack,
  output logic             o_rd_data_val,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_refill_val,
  input  logic [c_AW-1:0]  i_refill_addr,
  input  logic [WIDTH-1:0] i_refill_data,
  output logic             o_refill_ack,
  input  logic             i_upd_val,
  input  logic [c_AW-1:0]  i_upd_addr,
  input  logic [WIDTH-1:0] i_upd_data,
  output logic             o_upd_ack,
  input  logic             i_flush_req,
  output logic             o_flush_done,
  output logic             o_busy,
  output logic             o_mem_ren,
  output logic [c_AW-1:0]  o_mem_raddr,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_mem_wen,
  output logic [c_AW-1:0]  o_mem_waddr,
  output logic [WIDTH-1:0] o_mem_wdata
);

  localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_AW-1:0]   r_cnt;
  logic              r_pend;       // flush requested, sweep not yet started
  logic              r_rr;         // 0: refill favoured on a tie, 1: update favoured
  logic              r_rd_dv;
  logic              r_flush_done;

  logic              w_refill_ack;
  logic              w_upd_ack;
  logic              w_rd_ack;
  logic              w_busy;
  logic              w_conflict;
  logic              w_mem_ren;
  logic [c_AW-1:0]   w_mem_raddr;
  logic              w_mem_wen;
  logic [c_AW-1:0]   w_mem_waddr;
  logic [WIDTH-1:0]  w_mem_wdata;
  logic              w_flush_enter;
  logic              w_sweep_last;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, acks and array port drive
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_refill_ack = 1'b0;
    w_upd_ack    = 1'b0;
    w_rd_ack     = 1'b0;
    w_busy       = 1'b1;
    w_conflict   = 1'b0;
    w_mem_ren    = 1'b0;
    w_mem_raddr  = '0;
    w_mem_wen    = 1'b0;
    w_mem_waddr  = '0;
    w_mem_wdata  = '0;

    case (r_state)
      S_INIT: begin
        if (i_mem_ready) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        w_busy = 1'b0;
        // A lone requester always wins; on a tie the pointer decides.
        if (i_refill_val && (!i_upd_val || !r_rr)) begin
          w_refill_ack = 1'b1;
          w_mem_wen    = 1'b1;
          w_mem_waddr  = i_refill_addr;
          w_mem_wdata  = i_refill_data;
        end else if (i_upd_val) begin
          w_upd_ack    = 1'b1;
          w_mem_wen    = 1'b1;
          w_mem_waddr  = i_upd_addr;
          w_mem_wdata  = i_upd_data;
        end

        w_conflict = w_mem_wen && (i_rd_addr == w_mem_waddr);
`ifdef L1_LD_MEM_SCHED_BYPASS_EN
        w_rd_ack = i_rd_val;
`else
        // The array's read-during-write result is undefined, so hold the read off.
        w_rd_ack = i_rd_val && !w_conflict;
`endif
        if (w_rd_ack) begin
          w_mem_ren   = 1'b1;
          w_mem_raddr = i_rd_addr;
        end

        // Requests in this cycle are still served; the sweep starts at the edge.
        if (r_pend) begin
          w_state_nxt = S_FLUSH;
        end
      end

      S_FLUSH: begin
        w_mem_wen   = 1'b1;
        w_mem_waddr = r_cnt;
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_RUN;
        end
      end

      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign w_flush_enter = (r_state == S_RUN) && (w_state_nxt == S_FLUSH);
  assign w_sweep_last  = (r_state == S_FLUSH) && (r_cnt == c_LAST);

  // --------------------------------------------------------------------------
  // Sweep counter, pending flag, arbitration pointer, response timing
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_rr         <= 1'b0;
      r_rd_dv      <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      if ((r_state == S_FLUSH) && !w_sweep_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end

      // Entering the sweep consumes the request; a request seen during the
      // sweep re-arms the flag so another full sweep follows.
      if (w_flush_enter) begin
        r_pend <= 1'b0;
      end else if (i_flush_req) begin
        r_pend <= 1'b1;
      end

      if ((r_state == S_RUN) && i_refill_val && i_upd_val) begin
        r_rr <= ~r_rr;
      end

      r_rd_dv      <= w_rd_ack;
      r_flush_done <= w_sweep_last;
    end
  end

`ifdef L1_LD_MEM_SCHED_BYPASS_EN
  // --------------------------------------------------------------------------
  // Forwarding of write data to a colliding read
  // --------------------------------------------------------------------------
  logic             r_byp_sel;
  logic [WIDTH-1:0] r_byp_data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_byp_sel  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp_sel <= w_rd_ack && w_conflict;
      if (w_rd_ack && w_conflict) begin
        r_byp_data <= w_mem_wdata;
      end
    end
  end

  assign o_rd_data = r_rd_dv ? (r_byp_sel ? r_byp_data : i_mem_rdata) : '0;
`else
  assign o_rd_data = r_rd_dv ? i_mem_rdata : '0;
`endif

  assign o_rd_ack      = w_rd_ack;
  assign o_refill_ack  = w_refill_ack;
  assign o_upd_ack     = w_upd_ack;
  assign o_rd_data_val = r_rd_dv;
  assign o_flush_done  = r_flush_done;
  assign o_busy        = w_busy;
  assign o_mem_ren     = w_mem_ren;
  assign o_mem_raddr   = w_mem_raddr;
  assign o_mem_wen     = w_mem_wen;
  assign o_mem_waddr   = w_mem_waddr;
  assign o_mem_wdata   = w_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_l1_ld_mem_sched.sv
// ============================================================================
// Module   : tb_l1_ld_mem_sched
// Purpose  : Self-checking bench for l1_ld_mem_sched (DEPTH=16). It combines
//            directed scenarios with randomized RUN traffic. The random
//            traffic is checked against a golden memory image and an
//            arbitration-rule model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_ld_mem_sched;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef L1_LD_MEM_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             mem_ready = 1'b0;
  logic             rd_val = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic             rd_ack;
  logic             rd_data_val;
  logic [WIDTH-1:0] rd_data;
  logic             refill_val = 1'b0;
  logic [AW-1:0]    refill_addr = '0;
  logic [WIDTH-1:0] refill_data = '0;
  logic             refill_ack;
  logic             upd_val = 1'b0;
  logic [AW-1:0]    upd_addr = '0;
  logic [WIDTH-1:0] upd_data = '0;
  logic             upd_ack;
  logic             flush_req = 1'b0;
  logic             flush_done;
  logic             busy;
  logic             mem_ren;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_wen;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] arr  [DEPTH];  // the array the DUT drives
  logic [WIDTH-1:0] gold [DEPTH];  // what the array should hold

  always #5 CLK = ~CLK;

  l1_ld_mem_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .i_mem_ready   (mem_ready),
    .i_rd_val      (rd_val),
    .i_rd_addr     (rd_addr),
    .o_rd_ack      (rd_ack),
    .o_rd_data_val (rd_data_val),
    .o_rd_data     (rd_data),
    .i_refill_val  (refill_val),
    .i_refill_addr (refill_addr),
    .i_refill_data (refill_data),
    .o_refill_ack  (refill_ack),
    .i_upd_val     (upd_val),
    .i_upd_addr    (upd_addr),
    .i_upd_data    (upd_data),
    .o_upd_ack     (upd_ack),
    .i_flush_req   (flush_req),
    .o_flush_done  (flush_done),
    .o_busy        (busy),
    .o_mem_ren     (mem_ren),
    .o_mem_raddr   (mem_raddr),
    .i_mem_rdata   (mem_rdata),
    .o_mem_wen     (mem_wen),
    .o_mem_waddr   (mem_waddr),
    .o_mem_wdata   (mem_wdata)
  );

  // Synchronous-read array: the read returns the contents from before any same-edge write.
  always @(posedge CLK) begin
    if (mem_ren) mem_rdata <= arr[mem_raddr];
    if (mem_wen) arr[mem_waddr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"},
        {rd_ack, refill_ack, upd_ack, rd_data_val, flush_done, mem_ren, mem_wen, busy},
        8'b0000_0001);
    chk({tag, "_addr"}, {mem_raddr, mem_waddr}, '0);
    chk({tag, "_data"}, {rd_data, mem_wdata}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Random-traffic model state
  bit               fav_ref;
  bit               rv, uv, dv, e_ref, e_upd, e_wr, e_rd, exp_dv;
  logic [AW-1:0]    ra, ua, da, wa;
  logic [WIDTH-1:0] rdat, udat, wd, exp_rd;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      arr[i]  = '0;
      gold[i] = '0;
    end

    // ---------------- reset and INIT gating ----------------
    repeat (2) @(negedge CLK);
    chk_reset("reset");
    step();
    RST_N       = 1'b1;
    refill_val  = 1'b1;
    refill_addr = 4'd3;
    refill_data = 32'h0000_0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("init_refill_ack", refill_ack, 1'b0);
      chk("init_busy", busy, 1'b1);
      step();
    end
    mem_ready = 1'b1;
    @(negedge CLK);
    chk("init_last_ack", refill_ack, 1'b0);
    step();
    @(negedge CLK);
    chk("run_first_ack", refill_ack, 1'b1);
    chk("run_busy", busy, 1'b0);
    chk("run_first_waddr", mem_waddr, 4'd3);
    step();
    gold[3]    = 32'h0000_0011;
    refill_val = 1'b0;

    // ---------------- round robin on a persistent tie ----------------
    begin
      int ri, ui;
      ri = 0; ui = 0;
      refill_val = 1'b1; upd_val = 1'b1;
      for (int k = 0; k < 4; k++) begin
        refill_addr = AW'(1 + ri);  refill_data = 32'hA000_0000 + ri;
        upd_addr    = AW'(10 + ui); upd_data    = 32'hB000_0000 + ui;
        @(negedge CLK);
        chk("rr_refill_ack", refill_ack, (k % 2) == 0);
        chk("rr_upd_ack", upd_ack, (k % 2) == 1);
        chk("rr_waddr", mem_waddr, (k % 2) == 0 ? refill_addr : upd_addr);
        chk("rr_wdata", mem_wdata, (k % 2) == 0 ? refill_data : upd_data);
        step();
        if ((k % 2) == 0) begin gold[refill_addr] = refill_data; ri++; end
        else begin gold[upd_addr] = upd_data; ui++; end
      end
      refill_val = 1'b0; upd_val = 1'b0;
    end

    // ---------------- write then read ----------------
    refill_val = 1'b1; refill_addr = 4'd5; refill_data = 32'hA5A5_A5A5;
    @(negedge CLK);
    chk("wr5_ack", refill_ack, 1'b1);
    step();
    gold[5] = 32'hA5A5_A5A5;
    refill_val = 1'b0;
    rd_val = 1'b1; rd_addr = 4'd5;
    @(negedge CLK);
    chk("rd5_ack", {rd_ack, mem_ren, mem_raddr}, {1'b1, 1'b1, 4'd5});
    step();
    rd_val = 1'b0;
    @(negedge CLK);
    chk("rd5_dv", rd_data_val, 1'b1);
    chk("rd5_data", rd_data, 32'hA5A5_A5A5);
    step();

    // ---------------- same-cycle write/read collision ----------------
    upd_val = 1'b1; upd_addr = 4'd9; upd_data = 32'h0000_1234;
    rd_val  = 1'b1; rd_addr  = 4'd9;
    @(negedge CLK);
    chk("coll_upd_ack", upd_ack, 1'b1);
`ifdef L1_LD_MEM_SCHED_BYPASS_EN
    chk("coll_rd_ack", rd_ack, 1'b1);
    step();
    gold[9] = 32'h0000_1234;
    upd_val = 1'b0; rd_val = 1'b0;
`else
    chk("coll_rd_ack", rd_ack, 1'b0);
    step();
    gold[9] = 32'h0000_1234;
    upd_val = 1'b0;
    @(negedge CLK);
    chk("coll_rd_ack_retry", rd_ack, 1'b1);
    step();
    rd_val = 1'b0;
`endif
    @(negedge CLK);
    chk("coll_dv", rd_data_val, 1'b1);
    chk("coll_data", rd_data, 32'h0000_1234);
    step();

    // ---------------- randomized RUN traffic ----------------
    // Tie count so far is 4 (even), so refill is favoured again.
    fav_ref = 1'b1;
    rv = 0; uv = 0; dv = 0; exp_dv = 0; exp_rd = '0;
    ra = '0; ua = '0; da = '0; rdat = '0; udat = '0;
    for (int c = 0; c < 400; c++) begin
      if (!rv && $urandom_range(0, 2) != 0) begin
        rv = 1; ra = AW'($urandom_range(0, DEPTH - 1)); rdat = $urandom;
      end
      if (!uv && $urandom_range(0, 2) != 0) begin
        uv = 1; ua = AW'($urandom_range(0, DEPTH - 1)); udat = $urandom;
      end
      if (!dv && $urandom_range(0, 1) != 0) begin
        dv = 1; da = AW'($urandom_range(0, DEPTH - 1));
      end
      refill_val = rv; refill_addr = ra; refill_data = rdat;
      upd_val    = uv; upd_addr    = ua; upd_data    = udat;
      rd_val     = dv; rd_addr     = da;
      @(negedge CLK);
      e_ref = rv && (!uv || fav_ref);
      e_upd = uv && !e_ref;
      e_wr  = e_ref || e_upd;
      wa    = e_ref ? ra : ua;
      wd    = e_ref ? rdat : udat;
      e_rd  = dv && (BYP || !(e_wr && (da == wa)));
      chk("rnd_refill_ack", refill_ack, e_ref);
      chk("rnd_upd_ack", upd_ack, e_upd);
      chk("rnd_rd_ack", rd_ack, e_rd);
      chk("rnd_mem_wen", mem_wen, e_wr);
      if (e_wr) chk("rnd_wport", {mem_waddr, mem_wdata}, {wa, wd});
      chk("rnd_rd_dv", rd_data_val, exp_dv);
      if (exp_dv) chk("rnd_rd_data", rd_data, exp_rd);
      @(posedge CLK);
      if (rv && uv) fav_ref = !fav_ref;
      if (e_wr) gold[wa] = wd;
      exp_dv = e_rd;
      if (e_rd) exp_rd = gold[da];
      if (e_ref) rv = 0;
      if (e_upd) uv = 0;
      if (e_rd)  dv = 0;
      #1;
    end
    refill_val = 1'b0; upd_val = 1'b0; rd_val = 1'b0;
    @(negedge CLK);
    chk("rnd_drain_dv", rd_data_val, exp_dv);
    if (exp_dv) chk("rnd_drain_data", rd_data, exp_rd);
    step();

    // ---------------- full flush sweep ----------------
    flush_req = 1'b1;
    @(negedge CLK);
    chk("fl_req_busy", busy, 1'b0);
    step();
    flush_req = 1'b0;
    @(negedge CLK);
    chk("fl_pend_run", {busy, mem_wen, flush_done}, 3'b000);
    step();
    refill_val = 1'b1; refill_addr = 4'd4; refill_data = 32'h0000_0077;
    rd_val = 1'b1; rd_addr = 4'd12;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      chk("fl_wport", {mem_wen, mem_waddr, mem_wdata}, {1'b1, AW'(i), 32'h0});
      chk("fl_acks", {refill_ack, upd_ack, rd_ack}, 3'b000);
      chk("fl_busy_done", {busy, flush_done}, 2'b10);
      step();
    end
    @(negedge CLK);
    chk("fl_done", {flush_done, busy}, 2'b10);
    chk("fl_post_acks", {refill_ack, rd_ack}, 2'b11);
    step();
    for (int i = 0; i < DEPTH; i++) gold[i] = '0;
    gold[4] = 32'h0000_0077;
    refill_val = 1'b0;
    rd_addr = 4'd4;
    @(negedge CLK);
    chk("fl_rd12_data", {rd_data_val, rd_data}, {1'b1, 32'h0});
    chk("fl_done_pulse", flush_done, 1'b0);
    step();
    rd_val = 1'b0;
    @(negedge CLK);
    chk("fl_rd4_data", {rd_data_val, rd_data}, {1'b1, gold[4]});
    step();

    // ---------------- reset in the middle of a sweep ----------------
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    repeat (7) step();
    @(negedge CLK);
    chk("mid_waddr", {busy, mem_wen, mem_waddr}, {1'b1, 1'b1, 4'd7});
    RST_N = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk_reset("mid_reset");
    step();
    RST_N = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("mid_init", {busy, mem_wen}, 2'b10);
      step();
    end
    mem_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("mid_run_idle", {busy, mem_wen, flush_done}, 3'b000);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
